// File: rtl/seq_mul_div.sv
// seq_mul_div: iterative 32x32 multiply/divide unit.
// One radix-2 step per clock over a 64-bit {hi,lo} accumulator:
// shift-add for multiply, restoring shift-subtract for divide.
// Operands are reduced to magnitudes on accept, and the signs are fixed up in a final cycle.
module seq_mul_div #(
   parameter int N     = 32,
   parameter int CNT_W = 5
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [1:0]   op,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   output logic         busy,
   output logic         done,
   output logic [N-1:0] hi,
   output logic [N-1:0] lo,
   output logic         div_by_zero
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_FIX  = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

   // Two's complement negation of an N-bit value.
   function automatic logic [N-1:0] neg_n(input logic [N-1:0] v);
      return {N{1'b0}} - v;
   endfunction

   // Magnitude of a value, interpreted as signed only when is_sgn is set.
   function automatic logic [N-1:0] mag_n(input logic [N-1:0] v, input logic is_sgn);
      logic [N-1:0] r;
      if (is_sgn && v[N-1]) begin
         r = neg_n(v);
      end else begin
         r = v;
      end
      return r;
   endfunction

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2*N-1:0]   acc_q, acc_d;     // {hi,lo}: MUL {product}, DIV {rem,quo}
   logic [N-1:0]     opnd_q, opnd_d;   // MUL: |multiplicand|, DIV: |divisor|
   logic [N-1:0]     a_q, a_d;         // original dividend, returned on divide by zero
   logic             is_div_q, is_div_d;
   logic             neg_q, neg_d;     // negate product / quotient
   logic             neg_rem_q, neg_rem_d;
   logic             dbz_q, dbz_d;     // divide by zero detected at accept
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic [N-1:0]     hi_q, hi_d;
   logic [N-1:0]     lo_q, lo_d;
   logic             dbz_out_q, dbz_out_d;

   // Per-step datapath values derived from the accumulator.
   logic [N:0]       mul_sum_s;
   logic [2*N-1:0]   mul_next_s;
   logic [N:0]       div_tmp_s;
   logic [N+1:0]     div_diff_s;
   logic [2*N-1:0]   div_next_s;
   logic [2*N-1:0]   prod_neg_s;
   logic             op_div_s;
   logic             op_sgn_s;

   // One multiply step and one divide step, computed every cycle from the accumulator.
   always_comb begin
      mul_sum_s  = {1'b0, acc_q[2*N-1:N]} + {1'b0, opnd_q};
      if (acc_q[0]) begin
         mul_next_s = {mul_sum_s, acc_q[N-1:1]};
      end else begin
         mul_next_s = {1'b0, acc_q[2*N-1:1]};
      end
      div_tmp_s  = {acc_q[2*N-1:N], acc_q[N-1]};
      div_diff_s = {1'b0, div_tmp_s} - {2'b00, opnd_q};
      if (div_diff_s[N+1]) begin
         div_next_s = {div_tmp_s[N-1:0], acc_q[N-2:0], 1'b0};
      end else begin
         div_next_s = {div_diff_s[N-1:0], acc_q[N-2:0], 1'b1};
      end
      prod_neg_s = {(2*N){1'b0}} - acc_q;
   end

   // Decode of the requested operation; unused encodings fall back to unsigned multiply.
   always_comb begin
      op_div_s = 1'b0;
      op_sgn_s = 1'b0;
      case (op)
         2'b00:   begin op_div_s = 1'b0; op_sgn_s = 1'b0; end
         2'b01:   begin op_div_s = 1'b0; op_sgn_s = 1'b1; end
         2'b10:   begin op_div_s = 1'b1; op_sgn_s = 1'b0; end
         2'b11:   begin op_div_s = 1'b1; op_sgn_s = 1'b1; end
         default: begin op_div_s = 1'b0; op_sgn_s = 1'b0; end
      endcase
   end

   // Next-state and datapath control for IDLE -> CALC -> FIX.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      acc_d     = acc_q;
      opnd_d    = opnd_q;
      a_d       = a_q;
      is_div_d  = is_div_q;
      neg_d     = neg_q;
      neg_rem_d = neg_rem_q;
      dbz_d     = dbz_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      hi_d      = hi_q;
      lo_d      = lo_q;
      dbz_out_d = dbz_out_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               is_div_d  = op_div_s;
               a_d       = a;
               neg_d     = op_sgn_s & (a[N-1] ^ b[N-1]);
               neg_rem_d = op_sgn_s & op_div_s & a[N-1];
               dbz_d     = op_div_s & (b == {N{1'b0}});
               if (op_div_s) begin
                  opnd_d = mag_n(b, op_sgn_s);
                  acc_d  = {{N{1'b0}}, mag_n(a, op_sgn_s)};
               end else begin
                  opnd_d = mag_n(a, op_sgn_s);
                  acc_d  = {{N{1'b0}}, mag_n(b, op_sgn_s)};
               end
               cnt_d     = {CNT_W{1'b0}};
               busy_d    = 1'b1;
               dbz_out_d = 1'b0;
               state_d   = S_CALC;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_CALC: begin
            if (is_div_q) begin
               acc_d = div_next_s;
            end else begin
               acc_d = mul_next_s;
            end
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_LAST) begin
               state_d = S_FIX;
            end else begin
               state_d = S_CALC;
            end
         end
         S_FIX: begin
            if (!is_div_q) begin
               if (neg_q) begin
                  {hi_d, lo_d} = prod_neg_s;
               end else begin
                  {hi_d, lo_d} = acc_q;
               end
               dbz_out_d = 1'b0;
            end else if (dbz_q) begin
               lo_d      = {N{1'b1}};
               hi_d      = a_q;
               dbz_out_d = 1'b1;
            end else begin
               if (neg_q) begin
                  lo_d = neg_n(acc_q[N-1:0]);
               end else begin
                  lo_d = acc_q[N-1:0];
               end
               if (neg_rem_q) begin
                  hi_d = neg_n(acc_q[2*N-1:N]);
               end else begin
                  hi_d = acc_q[2*N-1:N];
               end
               dbz_out_d = 1'b0;
            end
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
         default: begin
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
      endcase
   end

   // State, datapath and output registers with asynchronous clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         cnt_q     <= {CNT_W{1'b0}};
         acc_q     <= {(2*N){1'b0}};
         opnd_q    <= {N{1'b0}};
         a_q       <= {N{1'b0}};
         is_div_q  <= 1'b0;
         neg_q     <= 1'b0;
         neg_rem_q <= 1'b0;
         dbz_q     <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         hi_q      <= {N{1'b0}};
         lo_q      <= {N{1'b0}};
         dbz_out_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         acc_q     <= acc_d;
         opnd_q    <= opnd_d;
         a_q       <= a_d;
         is_div_q  <= is_div_d;
         neg_q     <= neg_d;
         neg_rem_q <= neg_rem_d;
         dbz_q     <= dbz_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         dbz_out_q <= dbz_out_d;
      end
   end

   assign busy        = busy_q;
   assign done        = done_q;
   assign hi          = hi_q;
   assign lo          = lo_q;
   assign div_by_zero = dbz_out_q;

endmodule

// File: tb/tb_seq_mul_div.sv
// Testbench for seq_mul_div: directed vectors, expected results queued on issue
// and compared by an independent monitor whenever done is seen.
module tb_seq_mul_div;

   typedef struct packed {
      logic [31:0] hi;
      logic [31:0] lo;
      logic        dbz;
   } exp_t;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [1:0]  op;
   logic [31:0] a;
   logic [31:0] b;
   logic        busy;
   logic        done;
   logic [31:0] hi;
   logic [31:0] lo;
   logic        div_by_zero;

   int   errors = 0;
   int   checks = 0;
   exp_t exp_q[$];
   exp_t last_exp;

   seq_mul_div #(.N(32), .CNT_W(5)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .op          (op),
      .a           (a),
      .b           (b),
      .busy        (busy),
      .done        (done),
      .hi          (hi),
      .lo          (lo),
      .div_by_zero (div_by_zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Monitor: every done pulse must match the oldest queued expectation.
   always @(negedge clk) begin
      if (rst_n && done) begin
         if (exp_q.size() == 0) begin
            check("unexpected_done", 64'd1, 64'd0);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("hi", {32'd0, hi}, {32'd0, e.hi});
            check("lo", {32'd0, lo}, {32'd0, e.lo});
            check("div_by_zero", {63'd0, div_by_zero}, {63'd0, e.dbz});
         end
      end
   end

   // Called at a negedge: present the op, let one rising edge accept it.
   task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] eh, input logic [31:0] el, input logic ed,
                        input bit push);
      exp_t e;
      start = 1'b1;
      op    = o;
      a     = x;
      b     = y;
      @(posedge clk);
      #1;
      check("accepted_busy", {63'd0, busy}, 64'd1);
      start = 1'b0;
      op    = ~o;
      a     = ~x;
      b     = 32'hDEAD_BEEF;
      if (push) begin
         e.hi = eh;
         e.lo = el;
         e.dbz = ed;
         exp_q.push_back(e);
         last_exp = e;
      end
   endtask

   // Wait (bounded) for done; optionally pulse start with other operands mid-op.
   task automatic wait_done(input bit inject);
      int nbusy;
      bit got;
      nbusy = 0;
      got   = 1'b0;
      for (int i = 1; i <= 60; i++) begin
         @(negedge clk);
         if (inject && (i == 5 || i == 20)) begin
            start = 1'b1;
            op    = 2'b10;
            a     = 32'h0000_0005;
            b     = 32'h0000_0000;
         end else begin
            start = 1'b0;
         end
         if (done) begin
            got = 1'b1;
            break;
         end
         if (busy) nbusy++;
      end
      start = 1'b0;
      check("done_seen", {63'd0, got}, 64'd1);
      if (got) begin
         check("busy_cycles", 64'(nbusy), 64'd33);
         check("busy_low_at_done", {63'd0, busy}, 64'd0);
      end
   endtask

   // One cycle after done: pulse has ended and results are held.
   task automatic post_done();
      @(negedge clk);
      check("done_one_cycle", {63'd0, done}, 64'd0);
      check("idle_busy", {63'd0, busy}, 64'd0);
      check("hold_hi", {32'd0, hi}, {32'd0, last_exp.hi});
      check("hold_lo", {32'd0, lo}, {32'd0, last_exp.lo});
      check("hold_dbz", {63'd0, div_by_zero}, {63'd0, last_exp.dbz});
   endtask

   initial begin
      rst_n = 1'b0;
      start = 1'b0;
      op    = 2'b00;
      a     = 32'd0;
      b     = 32'd0;
      repeat (3) @(negedge clk);
      check("rst_busy", {63'd0, busy}, 64'd0);
      check("rst_done", {63'd0, done}, 64'd0);
      check("rst_hi", {32'd0, hi}, 64'd0);
      check("rst_lo", {32'd0, lo}, 64'd0);
      check("rst_dbz", {63'd0, div_by_zero}, 64'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // Directed vectors: {op, a, b, expected hi, expected lo, expected div_by_zero}
      issue(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 1'b1);
      wait_done(1'b0); post_done();
      issue(2'b01, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 1'b1);
      wait_done(1'b0); post_done();
      issue(2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0, 1'b1);
      wait_done(1'b0); post_done();
      issue(2'b11, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 1'b1);
      wait_done(1'b0); post_done();
      issue(2'b10, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 1'b1);
      wait_done(1'b0); post_done();
      issue(2'b10, 32'h0000_1234, 32'h0000_0000, 32'h0000_1234, 32'hFFFF_FFFF, 1'b1, 1'b1);
      wait_done(1'b0); post_done();
      issue(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0, 1'b1);
      wait_done(1'b0); post_done();
      issue(2'b11, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0, 1'b1);
      wait_done(1'b0); post_done();
      issue(2'b11, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0003, 1'b0, 1'b1);
      wait_done(1'b0); post_done();
      issue(2'b01, 32'h0000_0005, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1);
      wait_done(1'b0); post_done();

      // Start pulses while busy are ignored.
      issue(2'b00, 32'h1234_5678, 32'h0000_0010, 32'h0000_0001, 32'h2345_6780, 1'b0, 1'b1);
      wait_done(1'b1); post_done();

      // Start in the done cycle: back-to-back with no busy gap.
      issue(2'b10, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 1'b1);
      wait_done(1'b0);
      issue(2'b11, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0, 1'b1);
      wait_done(1'b0); post_done();

      // Reset in the middle of CALC abandons the op.
      issue(2'b00, 32'hFFFF_FFFF, 32'h0000_0003, 32'd0, 32'd0, 1'b0, 1'b0);
      repeat (10) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("midrst_busy", {63'd0, busy}, 64'd0);
      check("midrst_done", {63'd0, done}, 64'd0);
      check("midrst_hi", {32'd0, hi}, 64'd0);
      check("midrst_lo", {32'd0, lo}, 64'd0);
      check("midrst_dbz", {63'd0, div_by_zero}, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      issue(2'b10, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 1'b1);
      wait_done(1'b0); post_done();

      repeat (40) @(negedge clk);
      check("queue_drained", 64'(exp_q.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
